// File: rtl/alct_ly_pkg.sv
// Layer-wide constants and types shared by the one-shot stage, the drift
// stretcher and the pattern finder.
package alct_ly_pkg;

  localparam int LY_WIDTH = 112;
  localparam int CNT_W    = 3;
  localparam int OCC_W    = 7;

  typedef logic [LY_WIDTH-1:0] ly_t;

endpackage

// File: rtl/ly_drift_stretch_wire_stretch.sv
// One wire of the drift stretcher: a down-counter plus the output flop.
// A hit (re)loads the full window; trig_stop freezes both flops.
module wire_stretch #(
  parameter int CNT_W = alct_ly_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit,
  input  logic             trig_stop,
  input  logic [CNT_W-1:0] drift_delay,
  output logic             q
);

  logic [CNT_W-1:0] cnt;

  // Reload takes priority over the expiring count, so a retrigger on the
  // final cycle keeps q high without a gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (trig_stop) begin
      cnt <= cnt;
      q   <= q;
    end else if (hit) begin
      cnt <= drift_delay;
      q   <= 1'b1;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      q   <= 1'b1;
    end else begin
      q   <= 1'b0;
    end
  end

endmodule

// File: rtl/ly_drift_stretch.sv
// Per-layer drift-time stretcher: masks and stretches one-shotted wire hits,
// then registers the layer occupancy (popcount) and an any-hit flag.
module ly_drift_stretch #(
  parameter int LY_WIDTH = alct_ly_pkg::LY_WIDTH,
  parameter int CNT_W    = alct_ly_pkg::CNT_W,
  parameter int OCC_W    = alct_ly_pkg::OCC_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LY_WIDTH-1:0] lyr,
  input  logic [LY_WIDTH-1:0] hot_mask,
  input  logic [CNT_W-1:0]    drift_delay,
  input  logic                trig_stop,
  output logic [LY_WIDTH-1:0] lys,
  output logic [OCC_W-1:0]    ly_count,
  output logic                ly_any
);

  localparam int LEVELS = $clog2(LY_WIDTH);
  localparam int PAD_W  = 1 << LEVELS;

  logic [LY_WIDTH-1:0] hit;

  assign hit = lyr & hot_mask & {LY_WIDTH{~trig_stop}};

  genvar gi, gl;

  generate
    for (gi = 0; gi < LY_WIDTH; gi++) begin : g_wire
      wire_stretch #(
        .CNT_W(CNT_W)
      ) u_wire (
        .clk        (clk),
        .rst        (rst),
        .hit        (hit[gi]),
        .trig_stop  (trig_stop),
        .drift_delay(drift_delay),
        .q          (lys[gi])
      );
    end
  endgenerate

  // Binary adder tree over lys padded to a power of two; node width grows by
  // one bit per level but never exceeds OCC_W, which is enough for LY_WIDTH.
  generate
    for (gl = 0; gl <= LEVELS; gl++) begin : g_lvl
      localparam int N  = PAD_W >> gl;
      localparam int NW = (gl + 1 < OCC_W) ? gl + 1 : OCC_W;
      logic [NW-1:0] node [N];
      for (gi = 0; gi < N; gi++) begin : g_node
        if (gl == 0) begin : g_leaf
          if (gi < LY_WIDTH) begin : g_bit
            assign node[gi] = NW'(lys[gi]);
          end else begin : g_pad
            assign node[gi] = '0;
          end
        end else begin : g_add
          assign node[gi] = NW'(g_lvl[gl-1].node[2*gi]) + NW'(g_lvl[gl-1].node[2*gi+1]);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      ly_count <= '0;
      ly_any   <= 1'b0;
    end else begin
      ly_count <= OCC_W'(g_lvl[LEVELS].node[0]);
      ly_any   <= |lys;
    end
  end

endmodule

// File: tb/tb_ly_drift_stretch.sv
// Bench for ly_drift_stretch: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a deadline-based model.
module tb_ly_drift_stretch;
  import alct_ly_pkg::*;

  localparam int W = LY_WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic [W-1:0]     lyr;
  logic [W-1:0]     hot_mask;
  logic [CNT_W-1:0] drift_delay;
  logic             trig_stop;
  logic [W-1:0]     lys;
  logic [OCC_W-1:0] ly_count;
  logic             ly_any;

  always #5 clk = ~clk;

  ly_drift_stretch dut (
    .clk        (clk),
    .rst        (rst),
    .lyr        (lyr),
    .hot_mask   (hot_mask),
    .drift_delay(drift_delay),
    .trig_stop  (trig_stop),
    .lys        (lys),
    .ly_count   (ly_count),
    .ly_any     (ly_any)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: a global count of non-frozen edges; each wire is high while that
  // count has not passed the deadline set at its last load.
  longint       act;
  longint       deadline [W];
  bit           loaded [W];
  logic [W-1:0] exp_lys;
  logic [OCC_W-1:0] exp_cnt;
  logic         exp_any;
  bit           model_ok = 0;

  always @(posedge clk) begin
    if (rst) begin
      act = 0;
      for (int i = 0; i < W; i++) loaded[i] = 0;
      exp_lys = '0;
      exp_cnt = '0;
      exp_any = 1'b0;
      model_ok = 1;
    end else if (model_ok) begin
      exp_cnt = OCC_W'($countones(exp_lys));
      exp_any = (exp_lys != '0);
      if (!trig_stop) begin
        act++;
        for (int i = 0; i < W; i++)
          if (lyr[i] && hot_mask[i]) begin
            loaded[i]   = 1;
            deadline[i] = act + longint'(drift_delay);
          end
      end
      for (int i = 0; i < W; i++) exp_lys[i] = loaded[i] && (act <= deadline[i]);
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_lys", 128'(lys), 128'(exp_lys));
      chk("model_count", 128'(ly_count), 128'(exp_cnt));
      chk("model_any", 128'(ly_any), 128'(exp_any));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int e5 [6]  = '{1, 1, 1, 1, 0, 0};
  int ec5 [6] = '{0, 1, 1, 1, 1, 0};
  int e10 [6] = '{1, 1, 1, 1, 1, 0};

  initial begin
    rst = 1'b1; lyr = '0; hot_mask = '1; drift_delay = '0; trig_stop = 1'b0;
    step(); step();
    chk("reset_lys", 128'(lys), 128'd0);
    chk("reset_count", 128'(ly_count), 128'd0);
    chk("reset_any", 128'(ly_any), 128'd0);
    rst = 1'b0;
    step();

    // Single hit, D=3
    drift_delay = 3'd3; lyr[5] = 1'b1;
    step();
    lyr = '0;
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("single_lys5_%0d", j), 128'(lys[5]), 128'(e5[j]));
      chk($sformatf("single_count_%0d", j), 128'(ly_count), 128'(ec5[j]));
      chk($sformatf("single_any_%0d", j), 128'(ly_any), 128'(ec5[j] != 0));
      step();
    end
    $display("scenario single hit done");
    repeat (4) step();

    // Retrigger, D=2, hits at edges 0 and 2
    drift_delay = 3'd2;
    for (int j = 0; j < 6; j++) begin
      lyr = '0;
      if (j == 0 || j == 2) lyr[10] = 1'b1;
      step();
      chk($sformatf("retrig_lys10_%0d", j), 128'(lys[10]), 128'(e10[j]));
    end
    lyr = '0;
    $display("scenario retrigger done");
    repeat (4) step();

    // Masked wire and mask cleared mid-stretch
    hot_mask[20] = 1'b0; lyr[20] = 1'b1;
    step();
    lyr = '0;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("mask_lys20_%0d", j), 128'(lys[20]), 128'd0);
      step();
    end
    hot_mask = '1; drift_delay = 3'd5; lyr[21] = 1'b1;
    step();
    lyr = '0; hot_mask[21] = 1'b0;
    for (int j = 0; j < 7; j++) begin
      chk($sformatf("mask_lys21_%0d", j), 128'(lys[21]), 128'(j < 6));
      step();
    end
    hot_mask = '1;
    $display("scenario mask done");
    repeat (4) step();

    // Freeze, D=4
    drift_delay = 3'd4; lyr[0] = 1'b1;
    step();
    lyr = '0;
    step();
    trig_stop = 1'b1;
    for (int j = 0; j < 10; j++) begin
      lyr = '0;
      if (j == 3) lyr[1] = 1'b1;
      step();
      chk($sformatf("freeze_lys0_%0d", j), 128'(lys[0]), 128'd1);
      chk($sformatf("freeze_lys1_%0d", j), 128'(lys[1]), 128'd0);
      chk($sformatf("freeze_count_%0d", j), 128'(ly_count), 128'd1);
    end
    trig_stop = 1'b0; lyr = '0;
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("release_lys0_%0d", j), 128'(lys[0]), 128'(j < 3));
    end
    $display("scenario freeze done");
    repeat (4) step();

    // All wires, D=7, then reset mid-pulse
    drift_delay = 3'd7; lyr = '1;
    step();
    lyr = '0;
    chk("all_lys_0", 128'(lys), 128'({W{1'b1}}));
    for (int j = 1; j <= 9; j++) begin
      step();
      chk($sformatf("all_count_%0d", j), 128'(ly_count), 128'((j <= 8) ? W : 0));
    end
    lyr = '1;
    step();
    lyr = '0;
    step(); step();
    rst = 1'b1;
    step();
    chk("midrst_lys", 128'(lys), 128'd0);
    chk("midrst_count", 128'(ly_count), 128'd0);
    chk("midrst_any", 128'(ly_any), 128'd0);
    rst = 1'b0;
    step();
    $display("scenario full layer and reset done");

    // D=0, continuous hits on wire 111, then D changes
    drift_delay = 3'd0;
    for (int j = 0; j < 6; j++) begin
      lyr = '0; lyr[111] = 1'b1;
      step();
      chk($sformatf("cont_lys111_%0d", j), 128'(lys[111]), 128'd1);
    end
    lyr = '0; drift_delay = 3'd3;
    step();
    chk("dchg_idle", 128'(lys[111]), 128'd0);
    lyr[111] = 1'b1;
    step();
    lyr = '0; drift_delay = 3'd0;
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("dchg_lys111_%0d", j), 128'(lys[111]), 128'(j < 3));
    end
    $display("scenario drift delay change done");

    // Randomized run
    begin
      int stop_len = 0;
      for (int c = 0; c < 3000; c++) begin
        for (int i = 0; i < W; i++) lyr[i] = ($urandom_range(15) == 0);
        drift_delay = CNT_W'($urandom_range((1 << CNT_W) - 1));
        if ($urandom_range(31) == 0) begin
          hot_mask = '1;
          for (int k = 0; k < 6; k++) hot_mask[$urandom_range(W - 1)] = 1'b0;
        end
        if (stop_len > 0) stop_len--;
        else if ($urandom_range(40) == 0) stop_len = $urandom_range(12, 1);
        trig_stop = (stop_len > 0);
        rst = ($urandom_range(499) == 0);
        step();
      end
      rst = 1'b0; trig_stop = 1'b0; lyr = '0;
      repeat (10) step();
    end
    $display("scenario random done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
